// File: rtl/dense_result_tx.sv
// Arg-max and frame serialiser for one dense-layer result word.
// Emits HDR, class, logits as a byte stream. Results arriving while busy are dropped and counted.
module dense_result_tx #(
  parameter int unsigned NUM_CLASSES = 7,
  parameter int unsigned DATA_W      = 8,
  parameter logic [7:0]  HDR_BYTE    = 8'hA5
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLASSES*DATA_W-1:0] dense_out,
  input  logic                          dense_valid,
  output logic                          busy_o,
  output logic [2:0]                    class_o,
  output logic                          class_valid_o,
  output logic [7:0]                    tx_data_o,
  output logic                          tx_valid_o,
  input  logic                          tx_ready_i,
  output logic [7:0]                    drop_cnt_o
);

  localparam int unsigned IdxW     = 3;
  localparam int unsigned FrameLen = NUM_CLASSES + 2;
  localparam int unsigned ByteIdxW = $clog2(FrameLen);
  localparam logic [IdxW-1:0]     LastScan = IdxW'(NUM_CLASSES - 1);
  localparam logic [ByteIdxW-1:0] LastByte = ByteIdxW'(FrameLen - 1);

  typedef enum logic [1:0] {StIdle, StScan, StSend} state_e;

  state_e                          state_q, state_d;
  logic [NUM_CLASSES*DATA_W-1:0]   logits_q, logits_d;
  logic [DATA_W-1:0]               best_val_q, best_val_d;
  logic [IdxW-1:0]                 best_idx_q, best_idx_d;
  logic [IdxW-1:0]                 scan_idx_q, scan_idx_d;
  logic [ByteIdxW-1:0]             byte_idx_q, byte_idx_d;
  logic [IdxW-1:0]                 class_q, class_d;
  logic                            class_valid_q, class_valid_d;
  logic [7:0]                      tx_data_q, tx_data_d;
  logic                            tx_valid_q, tx_valid_d;
  logic [7:0]                      drop_cnt_q, drop_cnt_d;
  logic [DATA_W-1:0]               scan_val;
  logic                            scan_gt;

  function automatic logic [DATA_W-1:0] logit_at(input logic [NUM_CLASSES*DATA_W-1:0] v,
                                                 input logic [IdxW-1:0] i);
    logit_at = '0;
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (i == IdxW'(k)) logit_at = v[k*DATA_W +: DATA_W];
    end
  endfunction

  function automatic logic [7:0] frame_byte(input logic [ByteIdxW-1:0] idx,
                                            input logic [IdxW-1:0] cls,
                                            input logic [NUM_CLASSES*DATA_W-1:0] v);
    frame_byte = 8'h00;
    if (idx == '0) frame_byte = HDR_BYTE;
    if (idx == ByteIdxW'(1)) frame_byte = {5'b0, cls};
    for (int k = 0; k < NUM_CLASSES; k++) begin
      if (idx == ByteIdxW'(k + 2)) frame_byte = 8'(v[k*DATA_W +: DATA_W]);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (dense_valid) state_d = StScan;
      StScan:  if (scan_idx_q == LastScan) state_d = StSend;
      StSend:  if (tx_ready_i && byte_idx_q == LastByte) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign scan_val = logit_at(logits_q, scan_idx_q);
  // Strictly greater keeps the lowest index on ties.
  assign scan_gt  = $signed(scan_val) > $signed(best_val_q);

  always_comb begin
    logits_d      = logits_q;
    best_val_d    = best_val_q;
    best_idx_d    = best_idx_q;
    scan_idx_d    = scan_idx_q;
    byte_idx_d    = byte_idx_q;
    class_d       = class_q;
    class_valid_d = 1'b0;
    tx_data_d     = tx_data_q;
    tx_valid_d    = tx_valid_q;
    drop_cnt_d    = drop_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (dense_valid) begin
          logits_d   = dense_out;
          best_val_d = dense_out[DATA_W-1:0];
          best_idx_d = '0;
          scan_idx_d = IdxW'(1);
        end
      end
      StScan: begin
        if (scan_gt) begin
          best_val_d = scan_val;
          best_idx_d = scan_idx_q;
        end
        scan_idx_d = scan_idx_q + 1'b1;
        if (scan_idx_q == LastScan) begin
          class_d       = scan_gt ? scan_idx_q : best_idx_q;
          class_valid_d = 1'b1;
          byte_idx_d    = '0;
          tx_data_d     = HDR_BYTE;
          tx_valid_d    = 1'b1;
        end
      end
      StSend: begin
        if (tx_ready_i) begin
          if (byte_idx_q == LastByte) begin
            tx_valid_d = 1'b0;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
            tx_data_d  = frame_byte(byte_idx_q + 1'b1, class_q, logits_q);
          end
        end
      end
      default: ;
    endcase
    if (dense_valid && state_q != StIdle && drop_cnt_q != 8'hFF) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      logits_q      <= '0;
      best_val_q    <= '0;
      best_idx_q    <= '0;
      scan_idx_q    <= '0;
      byte_idx_q    <= '0;
      class_q       <= '0;
      class_valid_q <= 1'b0;
      tx_data_q     <= 8'h00;
      tx_valid_q    <= 1'b0;
      drop_cnt_q    <= 8'h00;
    end else begin
      logits_q      <= logits_d;
      best_val_q    <= best_val_d;
      best_idx_q    <= best_idx_d;
      scan_idx_q    <= scan_idx_d;
      byte_idx_q    <= byte_idx_d;
      class_q       <= class_d;
      class_valid_q <= class_valid_d;
      tx_data_q     <= tx_data_d;
      tx_valid_q    <= tx_valid_d;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  always_comb begin
    busy_o        = (state_q != StIdle);
    class_o       = class_q;
    class_valid_o = class_valid_q;
    tx_data_o     = tx_data_q;
    tx_valid_o    = tx_valid_q;
    drop_cnt_o    = drop_cnt_q;
  end

endmodule

// File: tb/tb_dense_result_tx.sv
// Scoreboard bench for dense_result_tx: stimulus pushes expected frames, a monitor pops and checks.
module tb_dense_result_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [55:0] dense_out = '0;
  logic        dense_valid = 1'b0;
  logic        busy_o;
  logic [2:0]  class_o;
  logic        class_valid_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b1;
  logic [7:0]  drop_cnt_o;

  dense_result_tx dut (
    .clk           (clk),
    .reset         (reset),
    .dense_out     (dense_out),
    .dense_valid   (dense_valid),
    .busy_o        (busy_o),
    .class_o       (class_o),
    .class_valid_o (class_valid_o),
    .tx_data_o     (tx_data_o),
    .tx_valid_o    (tx_valid_o),
    .tx_ready_i    (tx_ready_i),
    .drop_cnt_o    (drop_cnt_o)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int exp_drop = 0;
  int mode     = 0;  // 0 ready, 1 pattern 0,0,1, 2 not ready, 3 random
  int bp_base  = 0;
  int first_cyc = 0;
  int last_xfer_cyc = 0;

  logic [7:0] exp_bytes[$];
  int         exp_class[$];
  int         exp_cls_cyc[$];
  int         exp_start_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference arg-max: find the maximum, then the lowest index holding it.
  function automatic int ref_argmax(input logic [55:0] v);
    logic signed [7:0] s;
    int vals[7];
    int mx;
    for (int k = 0; k < 7; k++) begin
      s = v[k*8 +: 8];
      vals[k] = int'(s);
    end
    mx = vals[0];
    foreach (vals[k]) if (vals[k] > mx) mx = vals[k];
    for (int k = 0; k < 7; k++) if (vals[k] == mx) return k;
    return 0;
  endfunction

  always @(posedge clk) begin
    #2;
    case (mode)
      0: tx_ready_i = 1'b1;
      1: tx_ready_i = ((cyc - bp_base) % 3 == 2);
      2: tx_ready_i = 1'b0;
      default: tx_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = 8'h00;
  always @(negedge clk) begin
    if (reset) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        check("hold_valid", int'(tx_valid_o), 1);
        check("hold_data", int'(tx_data_o), int'(prev_d));
      end
      if (tx_valid_o && !prev_v) begin
        first_cyc = cyc;
        if (exp_start_cyc.size() == 0) check("unexpected_start", 1, 0);
        else check("start_cycle", cyc, exp_start_cyc.pop_front());
      end
      if (tx_valid_o && tx_ready_i) begin
        last_xfer_cyc = cyc;
        if (exp_bytes.size() == 0) check("unexpected_byte", int'(tx_data_o), -1);
        else check("tx_byte", int'(tx_data_o), int'(exp_bytes.pop_front()));
      end
      if (class_valid_o) begin
        if (exp_class.size() == 0) begin
          check("unexpected_class", int'(class_o), -1);
        end else begin
          check("class", int'(class_o), exp_class.pop_front());
          check("class_cycle", cyc, exp_cls_cyc.pop_front());
        end
      end
      prev_v = tx_valid_o;
      prev_r = tx_ready_i;
      prev_d = tx_data_o;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [55:0] v, input bit accept);
    dense_out   = v;
    dense_valid = 1'b1;
    if (accept) begin
      exp_class.push_back(ref_argmax(v));
      exp_cls_cyc.push_back(cyc + 7);
      exp_start_cyc.push_back(cyc + 7);
      exp_bytes.push_back(8'hA5);
      exp_bytes.push_back(8'(ref_argmax(v)));
      for (int k = 0; k < 7; k++) exp_bytes.push_back(v[k*8 +: 8]);
    end else begin
      exp_drop++;
    end
    idle(1);
    dense_valid = 1'b0;
  endtask

  task automatic check_drop(input string name);
    check(name, int'(drop_cnt_o), (exp_drop > 255) ? 255 : exp_drop);
  endtask

  task automatic wait_frame(input string name);
    int n = 0;
    while ((exp_bytes.size() != 0 || exp_class.size() != 0) && n < 3000) begin
      idle(1);
      n++;
    end
    check({name, "_timeout"}, exp_bytes.size(), 0);
    exp_bytes.delete();
    exp_class.delete();
    exp_cls_cyc.delete();
    check({name, "_busy_end"}, int'(busy_o), 0);
    check({name, "_valid_end"}, int'(tx_valid_o), 0);
  endtask

  initial begin
    int c0;
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    idle(3);
    check("rst_busy", int'(busy_o), 0);
    check("rst_class", int'(class_o), 0);
    check("rst_class_valid", int'(class_valid_o), 0);
    check("rst_tx_data", int'(tx_data_o), 0);
    check("rst_tx_valid", int'(tx_valid_o), 0);
    check("rst_drop", int'(drop_cnt_o), 0);
    reset = 1'b0;
    idle(2);

    // Basic, signed and tie cases under continuous ready.
    pulse(56'h05_10_F0_7F_80_22_01, 1'b1);
    wait_frame("basic");
    pulse(56'h33_33_33_33_33_33_33, 1'b1);
    wait_frame("tie");
    pulse(56'hFF_FE_FD_FC_FB_FA_F9, 1'b1);
    wait_frame("neg");
    pulse(56'h7F_80_80_80_80_80_80, 1'b1);
    wait_frame("max_last");

    // Backpressure 0,0,1: nine transfers spread over 27 cycles.
    c0 = cyc;
    bp_base = c0 + 7;
    mode = 1;
    pulse(56'h05_10_F0_7F_80_22_01, 1'b1);
    wait_frame("bp");
    check("bp_frame_time", last_xfer_cyc - first_cyc + 1, 27);
    mode = 0;
    idle(2);

    // Drops in SCAN, in SEND and on the last-byte handshake, then back-to-back accept.
    c0 = cyc;
    pulse(56'h01_02_03_04_05_06_07, 1'b1);
    idle(2);
    pulse(56'h7F_7F_7F_7F_7F_7F_7F, 1'b0);
    idle(6);
    pulse(56'h11_22_33_44_55_66_77, 1'b0);
    idle(3);
    check_drop("drop_two");
    idle(1);
    check("last_byte_cycle", cyc, c0 + 15);
    pulse(56'h00_00_00_00_00_00_00, 1'b0);
    pulse(56'h10_20_30_7E_30_20_10, 1'b1);
    wait_frame("b2b");
    check_drop("drop_three");

    // Saturation while downstream stalls.
    mode = 2;
    pulse(56'h0A_0B_0C_0D_0E_0F_01, 1'b1);
    idle(10);
    for (int i = 0; i < 300; i++) pulse(56'h0, 1'b0);
    check_drop("drop_sat");
    mode = 0;
    wait_frame("sat");

    // Reset after four bytes have transferred.
    c0 = cyc;
    pulse(56'h05_10_F0_7F_80_22_01, 1'b1);
    idle(2);
    pulse(56'h0, 1'b0);
    idle(7);
    check("rst_mid_bytes_left", exp_bytes.size(), 5);
    reset = 1'b1;
    mode = 2;
    idle(1);
    check("rst_mid_tx_valid", int'(tx_valid_o), 0);
    check("rst_mid_busy", int'(busy_o), 0);
    check("rst_mid_drop", int'(drop_cnt_o), 0);
    reset = 1'b0;
    exp_drop = 0;
    exp_bytes.delete();
    exp_class.delete();
    exp_cls_cyc.delete();
    exp_start_cyc.delete();
    mode = 0;
    idle(12);
    pulse(56'h05_10_F0_7F_80_22_01, 1'b1);
    wait_frame("post_rst");

    // Random logits, random ready, random drops during SCAN.
    mode = 3;
    for (int it = 0; it < 10; it++) begin
      logic [55:0] v;
      v = {$urandom, $urandom};
      if (it % 3 == 0) v[31:24] = v[15:8];
      pulse(v, 1'b1);
      for (int t = 1; t < 7; t++) begin
        if ($urandom_range(0, 2) == 0) pulse(56'({$urandom, $urandom}), 1'b0);
        else idle(1);
      end
      wait_frame("rand");
      check_drop("rand_drop");
    end
    mode = 0;
    idle(3);
    check("queue_start_empty", exp_start_cyc.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
